cpu_core_n: RTL and testbench
=============================

# cpu_core_n

Parametrised, handshaked successor to the fixed 8-bit three-input CPU top. It accepts one command per transaction over a valid/ready interface and selects two operands from NUM_IN data channels or from the result feedback. It executes an ALU or memory operation and writes a 2*WIDTH result register plus zero/error flags. Its sequencing is a 3-state FSM: the command register, operand registers, ALU, result mux, memory and flags sit in this one block.

## Interface
- WIDTH, 8, operand width; result/memory word is 2*WIDTH
- NUM_IN, 4, number of external data channels (>=1)
- MEM_DEPTH, 16, memory words (>=2, need not be a power of 2)
- Derived localparams: SELW = $clog2(NUM_IN+1), AW = $clog2(MEM_DEPTH)
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept; accept = cmd_valid && cmd_ready at a rising edge
- cmd_op  in  4  opcode
- cmd_sel_a, cmd_sel_b  in  SELW  operand select: 0..NUM_IN-1 = channel, NUM_IN = result[WIDTH-1:0], >NUM_IN invalid
- cmd_addr  in  AW  memory address for LOAD/STORE
- din  in  NUM_IN*WIDTH  channel k = din[k*WIDTH +: WIDTH]
- result  out  2*WIDTH  result register
- done  out  1  one-cycle completion pulse
- zero  out  1  result==0 after last command
- error  out  1  last command was invalid

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MUL, 7 SHL, 8 PASSA, 9 LOAD, 10 STORE, 11-15 invalid.
- Width rules (A, B zero-extended to 2*WIDTH):
  - ADD: A+B.
  - SUB: (A-B) mod 2^(2W); a negative result has all upper bits 1.
  - MUL: full 2W product.
  - SHL: A << B[$clog2(2W)-1:0], truncated to 2W.
  - AND/OR/XOR/PASSA: zero-extended.
- LOAD: result <= mem[addr] (synchronous read).
- STORE: mem[addr] <= result; result unchanged.
- NOP: result unchanged.
- Error when any of these holds: opcode invalid; sel_a or sel_b > NUM_IN (either select, for every opcode); addr >= MEM_DEPTH (LOAD/STORE only).
  - On error: result and memory unchanged, error=1, zero unchanged.
- Valid command: error=0 and zero=(new result==0), including NOP and STORE.
- FSM:
  - IDLE (cmd_ready=1): on accept, latch op, addr, error check and operands A/B (mux of din/feedback sampled at the accept edge) -> EXEC.
  - EXEC: ALU output or mem read captured into the stage register. STORE writes memory at this edge unless error. -> WB.
  - WB: result/flags written, done set -> IDLE.
- Operands are captured at accept; later changes on din, cmd_* or cmd_valid have no effect.
- The feedback operand uses the result value at the accept edge, i.e. the previous command's result.
- cmd_valid while in EXEC/WB is not accepted; the producer holds it and it is accepted in the next IDLE cycle.
- Memory contents are not reset; LOAD of a never-written address returns X. Benches write before read.

## Timing
- Reset values: result=0, zero=0, error=0, done=0, cmd_ready=0 while reset is high, FSM=IDLE.
- cmd_ready=1 in the first cycle after reset deasserts.
- Accept at edge E0, then EXEC edge E1, then WB edge E2.
- result/zero/error update at E2; done=1 for exactly the cycle after E2.
- cmd_ready=0 in the cycles after E0 and E1, and returns to 1 in the cycle after E2, coincident with done.
- Back-to-back throughput is one command per 3 cycles; the next accept can occur at E3.
- Reset high at any edge aborts the command. A STORE with reset high at E1 does not write memory. There is no done pulse for an aborted command.
- All outputs are registered; there is no combinational path from cmd_* or din to outputs.

## Test plan
- Default params (WIDTH=8, NUM_IN=4, MEM_DEPTH=16), all tests.
- Reset, then ADD sel_a=0 (din0=0xFF), sel_b=1 (din1=0x01):
  - cmd_ready low 2 cycles after accept.
  - done in the cycle after E2, result=0x0100, zero=0, error=0.
- SUB din0=0x03, din1=0x05 -> result=0xFFFE.
  - Then SUB 0x05-0x05 -> result=0x0000, zero=1.
- Feedback:
  - MUL 0xFF*0xFF -> 0xFE01.
  - ADD sel_a=4 (feedback 0x01), din2=0x10 -> 0x0011.
  - SHL din0=0x81, din1=0x04 -> 0x0810.
- Memory:
  - MUL -> 0xFE01, STORE addr 5, ADD -> 0x0002.
  - LOAD addr 5 -> result=0xFE01, zero=0.
- Errors:
  - op=12 -> error=1, result held, done still pulses.
  - sel_a=6 -> error=1.
  - Next valid ADD clears error.
- Abort and hold:
  - STORE addr 3 with reset pulsed during EXEC -> outputs return to reset values, no done.
  - A later LOAD 3 returns the previously written value.
  - cmd_valid held high through a busy period -> accepted exactly once per IDLE cycle.

Source files
------------

// File: rtl/cpu_core_n.sv
// Handshaked multi-channel CPU core: a command is accepted in IDLE, executed in EXEC and
// written back in WB. Operands come from NUM_IN data channels or the previous result.
module cpu_core_n #(
  parameter  int WIDTH     = 8,
  parameter  int NUM_IN    = 4,
  parameter  int MEM_DEPTH = 16,
  localparam int SELW      = $clog2(NUM_IN + 1),
  localparam int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [SELW-1:0]         cmd_sel_a,
  input  logic [SELW-1:0]         cmd_sel_b,
  input  logic [AW-1:0]           cmd_addr,
  input  logic [NUM_IN*WIDTH-1:0] din,
  output logic [2*WIDTH-1:0]      result,
  output logic                    done,
  output logic                    zero,
  output logic                    error
);

  localparam int W2  = 2 * WIDTH;
  localparam int SHW = $clog2(W2);
  localparam logic [SELW-1:0] FB_SEL  = SELW'(NUM_IN);
  localparam logic [AW:0]     DEPTH_W = (AW + 1)'(MEM_DEPTH);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_MUL   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_PASSA = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2} state_t;

  state_t            state_r;
  logic [3:0]        op_r;
  logic [AW-1:0]     addr_r;
  logic              err_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [W2-1:0]     stage_r;
  logic [W2-1:0]     mem_r [MEM_DEPTH];

  logic [WIDTH-1:0]  a_mux_s;
  logic [WIDTH-1:0]  b_mux_s;
  logic              cmd_err_s;
  logic              is_mem_s;
  logic [W2-1:0]     a_ext_s;
  logic [W2-1:0]     b_ext_s;
  logic [W2-1:0]     alu_s;

  // Channel select; any select at or above NUM_IN yields the feedback value (invalid ones flag error).
  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] sel,
                                            input logic [NUM_IN*WIDTH-1:0] d,
                                            input logic [WIDTH-1:0] fb);
    logic [WIDTH-1:0] v;
    v = fb;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SELW'(k)) v = d[k*WIDTH +: WIDTH];
    end
    return v;
  endfunction

  assign a_mux_s   = pick(cmd_sel_a, din, result[WIDTH-1:0]);
  assign b_mux_s   = pick(cmd_sel_b, din, result[WIDTH-1:0]);
  assign is_mem_s  = (cmd_op == OP_LOAD) || (cmd_op == OP_STORE);
  assign cmd_err_s = (cmd_op > OP_STORE) || (cmd_sel_a > FB_SEL) || (cmd_sel_b > FB_SEL) ||
                     (is_mem_s && ({1'b0, cmd_addr} >= DEPTH_W));
  assign a_ext_s   = {{WIDTH{1'b0}}, a_r};
  assign b_ext_s   = {{WIDTH{1'b0}}, b_r};

  // ALU / memory read mux; NOP, STORE and invalid opcodes carry the current result forward.
  always_comb begin
    alu_s = result;
    case (op_r)
      OP_ADD:   alu_s = a_ext_s + b_ext_s;
      OP_SUB:   alu_s = a_ext_s - b_ext_s;
      OP_AND:   alu_s = a_ext_s & b_ext_s;
      OP_OR:    alu_s = a_ext_s | b_ext_s;
      OP_XOR:   alu_s = a_ext_s ^ b_ext_s;
      OP_MUL:   alu_s = a_ext_s * b_ext_s;
      OP_SHL:   alu_s = a_ext_s << b_r[SHW-1:0];
      OP_PASSA: alu_s = a_ext_s;
      OP_LOAD:  alu_s = err_r ? result : mem_r[addr_r];
      default:  alu_s = result;
    endcase
  end

  // Memory write at the EXEC edge; a reset at that edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == EXEC) && (op_r == OP_STORE) && !err_r) begin
      mem_r[addr_r] <= result;
    end
  end

  // Sequencing FSM with registered handshake, result and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      result    <= {W2{1'b0}};
      zero      <= 1'b0;
      error     <= 1'b0;
      op_r      <= OP_NOP;
      addr_r    <= {AW{1'b0}};
      err_r     <= 1'b0;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      stage_r   <= {W2{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            op_r      <= cmd_op;
            addr_r    <= cmd_addr;
            err_r     <= cmd_err_s;
            a_r       <= a_mux_s;
            b_r       <= b_mux_s;
            cmd_ready <= 1'b0;
            state_r   <= EXEC;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        EXEC: begin
          stage_r <= alu_s;
          state_r <= WB;
        end
        WB: begin
          if (err_r) begin
            error <= 1'b1;
          end else begin
            result <= stage_r;
            zero   <= (stage_r == {W2{1'b0}});
            error  <= 1'b0;
          end
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_n.sv
// Self-checking bench for cpu_core_n: directed vector table, reset-abort and hold sequences,
// then randomized commands against an arithmetic reference model.
module tb_cpu_core_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_sel_a;
  logic [2:0]  cmd_sel_b;
  logic [3:0]  cmd_addr;
  logic [31:0] din;
  logic [15:0] result;
  logic        done;
  logic        zero;
  logic        error;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_res;
  bit m_z;
  bit m_e;
  int m_mem [16];
  bit m_wr  [16];

  always #5 clk = ~clk;

  cpu_core_n #(.WIDTH(8), .NUM_IN(4), .MEM_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel_a(cmd_sel_a), .cmd_sel_b(cmd_sel_b), .cmd_addr(cmd_addr),
    .din(din), .result(result), .done(done), .zero(zero), .error(error)
  );

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  sa;
    logic [2:0]  sb;
    logic [3:0]  ad;
    logic [31:0] d;
    logic [15:0] res;
    logic        z;
    logic        e;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic from the opcode rules, updates model state.
  task automatic model_step(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                            input logic [3:0] ad, input logic [31:0] d,
                            output logic [15:0] er, output logic ez, output logic ee);
    int a, b, r;
    bit err;
    a = (sa < 4) ? int'((d >> (sa * 8)) & 32'hFF) : (m_res & 255);
    b = (sb < 4) ? int'((d >> (sb * 8)) & 32'hFF) : (m_res & 255);
    err = (op > 10) || (sa > 4) || (sb > 4);
    r = m_res;
    if (!err) begin
      case (op)
        1:  r = a + b;
        2:  r = (a - b) & 65535;
        3:  r = a & b;
        4:  r = a | b;
        5:  r = a ^ b;
        6:  r = a * b;
        7:  r = (a << (b % 16)) & 65535;
        8:  r = a;
        9:  r = m_mem[ad];
        10: begin m_mem[ad] = m_res; m_wr[ad] = 1'b1; end
        default: r = m_res;
      endcase
      m_res = r;
      m_z   = (r == 0);
      m_e   = 1'b0;
    end else begin
      m_e = 1'b1;
    end
    er = 16'(m_res);
    ez = m_z;
    ee = m_e;
  endtask

  // Full transaction with cycle-accurate handshake checks; called at a negedge.
  task automatic do_cmd(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                        input logic [3:0] ad, input logic [31:0] d,
                        input logic [15:0] er, input logic ez, input logic ee, input string name);
    int n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk({name, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_sel_a = sa; cmd_sel_b = sb; cmd_addr = ad; din = d;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = 4'($urandom); cmd_sel_a = 3'($urandom);
    cmd_sel_b = 3'($urandom); cmd_addr = 4'($urandom); din = $urandom;
    chk({name, "_busy1"}, {30'd0, cmd_ready, done}, 32'd0);
    @(negedge clk);
    chk({name, "_busy2"}, {30'd0, cmd_ready, done}, 32'd0);
    @(negedge clk);
    chk({name, "_done"}, {30'd0, cmd_ready, done}, 32'd3);
    chk({name, "_result"}, {16'd0, result}, {16'd0, er});
    chk({name, "_flags"}, {30'd0, zero, error}, {30'd0, ez, ee});
  endtask

  initial begin
    logic [15:0] er;
    logic ez, ee;
    int dn;
    logic [3:0] op;
    logic [2:0] sa, sb;
    logic [3:0] ad;
    logic [31:0] d;

    tbl[0]  = '{4'd1,  3'd0, 3'd1, 4'd0, 32'h000001FF, 16'h0100, 1'b0, 1'b0};
    tbl[1]  = '{4'd2,  3'd0, 3'd1, 4'd0, 32'h00000503, 16'hFFFE, 1'b0, 1'b0};
    tbl[2]  = '{4'd0,  3'd0, 3'd1, 4'd0, 32'h00000000, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{4'd2,  3'd0, 3'd1, 4'd0, 32'h00000505, 16'h0000, 1'b1, 1'b0};
    tbl[4]  = '{4'd6,  3'd0, 3'd1, 4'd0, 32'h0000FFFF, 16'hFE01, 1'b0, 1'b0};
    tbl[5]  = '{4'd1,  3'd0, 3'd1, 4'd0, 32'h00000001, 16'h0001, 1'b0, 1'b0};
    tbl[6]  = '{4'd1,  3'd4, 3'd2, 4'd0, 32'h00100000, 16'h0011, 1'b0, 1'b0};
    tbl[7]  = '{4'd7,  3'd0, 3'd1, 4'd0, 32'h00000481, 16'h0810, 1'b0, 1'b0};
    tbl[8]  = '{4'd3,  3'd0, 3'd1, 4'd0, 32'h00003CF0, 16'h0030, 1'b0, 1'b0};
    tbl[9]  = '{4'd4,  3'd0, 3'd1, 4'd0, 32'h00003CF0, 16'h00FC, 1'b0, 1'b0};
    tbl[10] = '{4'd5,  3'd0, 3'd1, 4'd0, 32'h00003CF0, 16'h00CC, 1'b0, 1'b0};
    tbl[11] = '{4'd6,  3'd2, 3'd3, 4'd0, 32'hFFFF0000, 16'hFE01, 1'b0, 1'b0};
    tbl[12] = '{4'd10, 3'd0, 3'd0, 4'd5, 32'h00000000, 16'hFE01, 1'b0, 1'b0};
    tbl[13] = '{4'd1,  3'd0, 3'd1, 4'd0, 32'h00000101, 16'h0002, 1'b0, 1'b0};
    tbl[14] = '{4'd9,  3'd0, 3'd0, 4'd5, 32'h00000000, 16'hFE01, 1'b0, 1'b0};
    tbl[15] = '{4'd12, 3'd0, 3'd1, 4'd0, 32'h00000101, 16'hFE01, 1'b0, 1'b1};
    tbl[16] = '{4'd1,  3'd6, 3'd1, 4'd0, 32'h00000101, 16'hFE01, 1'b0, 1'b1};
    tbl[17] = '{4'd1,  3'd0, 3'd1, 4'd0, 32'h00000101, 16'h0002, 1'b0, 1'b0};
    tbl[18] = '{4'd10, 3'd0, 3'd0, 4'd3, 32'h00000000, 16'h0002, 1'b0, 1'b0};
    tbl[19] = '{4'd8,  3'd0, 3'd1, 4'd0, 32'h00000077, 16'h0077, 1'b0, 1'b0};

    m_res = 0; m_z = 1'b0; m_e = 1'b0;
    for (int i = 0; i < 16; i++) begin m_mem[i] = 0; m_wr[i] = 1'b0; end

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_sel_a = 3'd0; cmd_sel_b = 3'd0;
    cmd_addr = 4'd0; din = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {12'd0, result, zero, error, done, cmd_ready}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 20; i++) begin
      model_step(tbl[i].op, tbl[i].sa, tbl[i].sb, tbl[i].ad, tbl[i].d, er, ez, ee);
      do_cmd(tbl[i].op, tbl[i].sa, tbl[i].sb, tbl[i].ad, tbl[i].d,
             tbl[i].res, tbl[i].z, tbl[i].e, $sformatf("vec%0d", i));
      if (i == 0) begin
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
      end
    end

    // STORE to addr 3 aborted by reset at the EXEC edge
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd10; cmd_addr = 4'd3; cmd_sel_a = 3'd0; cmd_sel_b = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {12'd0, result, zero, error, done, cmd_ready}, 32'd0);
    reset = 1'b0;
    m_res = 0; m_z = 1'b0; m_e = 1'b0;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);
    model_step(4'd9, 3'd0, 3'd0, 4'd3, 32'd0, er, ez, ee);
    do_cmd(4'd9, 3'd0, 3'd0, 4'd3, 32'd0, 16'h0002, 1'b0, 1'b0, "load_after_abort");

    // cmd_valid held through busy periods: one accept per IDLE window
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_sel_a = 3'd4; cmd_sel_b = 3'd0; din = 32'h00000001;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    cmd_valid = 1'b0;
    repeat (4) model_step(4'd1, 3'd4, 3'd0, 4'd0, 32'h1, er, ez, ee);
    chk("hold_done_count", 32'(dn), 32'd4);
    chk("hold_result", {16'd0, result}, {16'd0, er});

    // randomized commands against the model
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      sa = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      sb = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      ad = 4'($urandom);
      d  = $urandom;
      if (op == 4'd9 && !m_wr[ad]) op = 4'd10;
      model_step(op, sa, sb, ad, d, er, ez, ee);
      do_cmd(op, sa, sb, ad, d, er, ez, ee, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
